// File: rtl/ofm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofm_pkg
// Purpose  : Shared field offsets, widths and FSM encoding for the OFM TX reader
// Revision : 1.0
// ============================================================================
package ofm_pkg;

    localparam int CTRL_W        = 64;
    localparam int DATA_W        = 73;
    localparam int KEEP_W        = 8;
    localparam int TDATA_W       = 64;

    localparam int CTRL_LEN_LSB  = 0;
    localparam int CTRL_LEN_W    = 16;
    localparam int CTRL_DROP_BIT = 16;

    localparam int DATA_LSB      = 0;
    localparam int DATA_KEEP_LSB = 64;
    localparam int DATA_LAST_BIT = 72;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic logic [3:0] popcount8(input logic [KEEP_W-1:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofm_axis_reg.sv
`default_nettype none
// ============================================================================
// Module   : ofm_axis_reg
// Purpose  : One-entry AXI-Stream output stage; holds a beat until accepted
// Revision : 1.0
// ============================================================================
module ofm_axis_reg
    import ofm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TDATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0]  in_keep,
    input  logic               in_last,
    input  logic               in_user,
    output logic               tvalid,
    output logic [TDATA_W-1:0] tdata,
    output logic [KEEP_W-1:0]  tkeep,
    output logic               tlast,
    output logic               tuser,
    input  logic               tready
);

    // The producer only asserts load when the stage is empty or draining,
    // so a load always wins over the accept-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tkeep  <= '0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= in_data;
            tkeep  <= in_keep;
            tlast  <= in_last;
            tuser  <= in_user;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofm_tx_reader.sv
`default_nettype none
// ============================================================================
// Module   : ofm_tx_reader
// Purpose  : Pops ctrl/data FIFOs and streams frames to the MAC over AXI-Stream
// Revision : 1.0
// ============================================================================
module ofm_tx_reader
    import ofm_pkg::*;
#(
    parameter int C_LEN_CHECK  = 1,
    parameter int C_UNDERRUN_W = 16
) (
    input  logic                    tx_clk,
    input  logic                    tx_resetn,
    input  logic [CTRL_W-1:0]       ctrl_fifo_rdata,
    input  logic                    ctrl_fifo_empty,
    output logic                    ctrl_fifo_rden,
    input  logic [DATA_W-1:0]       data_fifo_rdata,
    input  logic                    data_fifo_empty,
    output logic                    data_fifo_rden,
    output logic [TDATA_W-1:0]      tx_axis_tdata,
    output logic [KEEP_W-1:0]       tx_axis_tkeep,
    output logic                    tx_axis_tlast,
    output logic                    tx_axis_tuser,
    output logic                    tx_axis_tvalid,
    input  logic                    tx_axis_tready,
    input  logic                    enable,
    output logic                    busy,
    output logic                    len_err,
    output logic                    drop_pulse,
    output logic [31:0]             frame_cnt,
    output logic [C_UNDERRUN_W-1:0] underrun_cnt
);

    state_t                state;
    logic                  run;
    logic [CTRL_LEN_W-1:0] frame_len;
    logic [CTRL_LEN_W-1:0] byte_cnt;
    logic [CTRL_LEN_W-1:0] beat_total;
    logic                  len_mismatch;
    logic                  ctrl_pop;
    logic                  send_pop;
    logic                  drop_pop;
    logic                  unused_ctrl_bits;

    logic [TDATA_W-1:0]    d_data;
    logic [KEEP_W-1:0]     d_keep;
    logic                  d_last;

    assign d_data = data_fifo_rdata[DATA_LSB +: TDATA_W];
    assign d_keep = data_fifo_rdata[DATA_KEEP_LSB +: KEEP_W];
    assign d_last = data_fifo_rdata[DATA_LAST_BIT];

    assign unused_ctrl_bits = ^ctrl_fifo_rdata[CTRL_W-1:CTRL_DROP_BIT+1];

    // run blocks the ctrl pop while in reset and for the first cycle after it
    assign ctrl_pop = run & (state == ST_IDLE) & enable & ~ctrl_fifo_empty;
    assign send_pop = (state == ST_SEND) & ~data_fifo_empty
                    & (~tx_axis_tvalid | tx_axis_tready);
    assign drop_pop = (state == ST_DROP) & ~data_fifo_empty;

    assign ctrl_fifo_rden = ctrl_pop;
    assign data_fifo_rden = send_pop | drop_pop;

    assign beat_total = byte_cnt + CTRL_LEN_W'(popcount8(d_keep));

    generate
        if (C_LEN_CHECK != 0) begin : g_len_check
            assign len_mismatch = d_last & (beat_total != frame_len);
        end else begin : g_no_len_check
            assign len_mismatch = 1'b0;
        end
    endgenerate

    assign busy = (state != ST_IDLE) | tx_axis_tvalid;

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            state      <= ST_IDLE;
            run        <= 1'b0;
            frame_len  <= '0;
            byte_cnt   <= '0;
            len_err    <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            run        <= 1'b1;
            len_err    <= 1'b0;
            drop_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctrl_pop) begin
                        frame_len <= ctrl_fifo_rdata[CTRL_LEN_LSB +: CTRL_LEN_W];
                        byte_cnt  <= '0;
                        state     <= ctrl_fifo_rdata[CTRL_DROP_BIT] ? ST_DROP : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (send_pop) begin
                        byte_cnt <= beat_total;
                        if (d_last) begin
                            len_err <= len_mismatch;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (drop_pop && d_last) begin
                        drop_pulse <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            if (tx_axis_tvalid && tx_axis_tready && tx_axis_tlast) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            if ((state == ST_SEND) && data_fifo_empty && !tx_axis_tvalid
                && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + C_UNDERRUN_W'(1);
            end
        end
    end

    ofm_axis_reg u_axis_reg (
        .clk     (tx_clk),
        .rst_n   (tx_resetn),
        .load    (send_pop),
        .in_data (d_data),
        .in_keep (d_keep),
        .in_last (d_last),
        .in_user (len_mismatch),
        .tvalid  (tx_axis_tvalid),
        .tdata   (tx_axis_tdata),
        .tkeep   (tx_axis_tkeep),
        .tlast   (tx_axis_tlast),
        .tuser   (tx_axis_tuser),
        .tready  (tx_axis_tready)
    );

endmodule
`default_nettype wire

// File: tb/tb_ofm_tx_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofm_tx_reader
// Purpose  : Randomized bench for ofm_tx_reader with FIFO models and a beat scoreboard
// Revision : 1.0
// ============================================================================
module tb_ofm_tx_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] ctrl_rdata;
    logic        ctrl_empty, ctrl_rden, nc_ctrl_rden;
    logic [72:0] data_rdata;
    logic        data_empty, data_rden, nc_data_rden;
    logic [63:0] tdata, nc_tdata;
    logic [7:0]  tkeep, nc_tkeep;
    logic        tlast, nc_tlast, tuser, nc_tuser, tvalid, nc_tvalid, tready;
    logic        enable, busy, nc_busy, len_err, nc_len_err, drop_pulse, nc_drop_pulse;
    logic [31:0] frame_cnt, nc_frame_cnt;
    logic [15:0] underrun_cnt, nc_underrun_cnt;

    ofm_tx_reader #(.C_LEN_CHECK(1), .C_UNDERRUN_W(16)) dut (
        .tx_clk(clk), .tx_resetn(rst_n),
        .ctrl_fifo_rdata(ctrl_rdata), .ctrl_fifo_empty(ctrl_empty), .ctrl_fifo_rden(ctrl_rden),
        .data_fifo_rdata(data_rdata), .data_fifo_empty(data_empty), .data_fifo_rden(data_rden),
        .tx_axis_tdata(tdata), .tx_axis_tkeep(tkeep), .tx_axis_tlast(tlast), .tx_axis_tuser(tuser),
        .tx_axis_tvalid(tvalid), .tx_axis_tready(tready),
        .enable(enable), .busy(busy), .len_err(len_err), .drop_pulse(drop_pulse),
        .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
    );

    // Length check disabled; shares every input so its pops match the main DUT
    ofm_tx_reader #(.C_LEN_CHECK(0), .C_UNDERRUN_W(16)) dut_nc (
        .tx_clk(clk), .tx_resetn(rst_n),
        .ctrl_fifo_rdata(ctrl_rdata), .ctrl_fifo_empty(ctrl_empty), .ctrl_fifo_rden(nc_ctrl_rden),
        .data_fifo_rdata(data_rdata), .data_fifo_empty(data_empty), .data_fifo_rden(nc_data_rden),
        .tx_axis_tdata(nc_tdata), .tx_axis_tkeep(nc_tkeep), .tx_axis_tlast(nc_tlast), .tx_axis_tuser(nc_tuser),
        .tx_axis_tvalid(nc_tvalid), .tx_axis_tready(tready),
        .enable(enable), .busy(nc_busy), .len_err(nc_len_err), .drop_pulse(nc_drop_pulse),
        .frame_cnt(nc_frame_cnt), .underrun_cnt(nc_underrun_cnt)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    logic [63:0] ctrl_q[$];
    logic [72:0] data_q[$];
    beat_t       exp_q[$];

    logic ctrl_hold, data_hold;
    int   ready_mode;     // 0: always ready, 1: toggle, 2: random
    bit   rand_env;       // random data gaps and enable toggling

    int vectors, miscompares;
    int cyc;
    int ctrl_pop_cyc, data_pop_cyc, tvalid_cyc, last_cyc;
    int n_lenerr, n_lenerr_nc, n_drop, n_illegal, n_ctrl_pops, n_data_pops;
    int exp_frame_cnt, exp_lenerr, exp_drops, exp_data_pops;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic [9:0]  prev_side;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        ctrl_empty = ctrl_hold || (ctrl_q.size() == 0);
        ctrl_rdata = (ctrl_q.size() != 0) ? ctrl_q[0] : 64'h0;
        data_empty = data_hold || (data_q.size() == 0);
        data_rdata = (data_q.size() != 0) ? data_q[0] : 73'h0;
    endtask

    // len_fix >= 0 gives the ctrl length directly; otherwise length = bytes + len_off
    task automatic push_frame(input int len_fix, input int len_off, input bit drop,
                              input int nbeats, input bit rand_keep, input logic [7:0] last_keep);
        beat_t fq[$];
        beat_t b;
        int    total;
        logic [15:0] len;
        total = 0;
        for (int i = 0; i < nbeats; i++) begin
            b.d = {$urandom(), $urandom()};
            b.l = (i == nbeats - 1);
            b.k = b.l ? last_keep : (rand_keep ? 8'($urandom()) : 8'hFF);
            b.u = 1'b0;
            total += $countones(b.k);
            data_q.push_back({b.l, b.k, b.d});
            exp_data_pops++;
            fq.push_back(b);
        end
        len = (len_fix >= 0) ? 16'(len_fix) : 16'(total + len_off);
        ctrl_q.push_back({$urandom(), 15'($urandom()), drop, len});
        fq[nbeats-1].u = (len != 16'(total));
        if (drop) begin
            exp_drops++;
        end else begin
            if (fq[nbeats-1].u) exp_lenerr++;
            foreach (fq[i]) exp_q.push_back(fq[i]);
        end
        drive_fifo();
    endtask

    task automatic mark_reset();
        ctrl_pop_cyc = -1;
        data_pop_cyc = -1;
        tvalid_cyc   = -1;
        last_cyc     = -1;
    endtask

    // One clock: observe at the falling edge, apply FIFO pops and new stimulus just after the rising edge
    task automatic step();
        beat_t e;
        logic  c_pop, d_pop;
        @(negedge clk);
        cyc++;
        c_pop = ctrl_rden;
        d_pop = data_rden;
        if (c_pop && ctrl_empty) n_illegal++;
        if (d_pop && data_empty) n_illegal++;
        if (c_pop) begin
            n_ctrl_pops++;
            if (ctrl_pop_cyc < 0) ctrl_pop_cyc = cyc;
        end
        if (d_pop) begin
            n_data_pops++;
            if (data_pop_cyc < 0) data_pop_cyc = cyc;
        end
        if (tvalid && tvalid_cyc < 0) tvalid_cyc = cyc;
        if (prev_stall) begin
            check("stall_valid", tvalid, 1'b1);
            check("stall_data", tdata, prev_data);
            check("stall_side", {tkeep, tlast, tuser}, prev_side);
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_side  = {tkeep, tlast, tuser};
        if (len_err)    n_lenerr++;
        if (nc_len_err) n_lenerr_nc++;
        if (drop_pulse) n_drop++;
        if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", tvalid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("tdata", tdata, e.d);
                check("tkeep", tkeep, e.k);
                check("tlast", tlast, e.l);
                check("tuser", tuser, e.u);
                check("tuser_nocheck", nc_tuser, 1'b0);
                if (e.l) begin
                    exp_frame_cnt++;
                    last_cyc = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        if (c_pop && ctrl_q.size() != 0) void'(ctrl_q.pop_front());
        if (d_pop && data_q.size() != 0) void'(data_q.pop_front());
        case (ready_mode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = ($urandom_range(0, 2) != 0);
        endcase
        if (rand_env) begin
            data_hold = ($urandom_range(0, 4) == 0);
            enable    = ($urandom_range(0, 7) != 0);
        end
        drive_fifo();
    endtask

    task automatic finish_scn(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(ctrl_q.size() == 0 && data_q.size() == 0 && exp_q.size() == 0 && !busy)) begin
            step();
            n++;
        end
        step();
        step();
        check({name, "_exp_drained"}, exp_q.size(), 0);
        check({name, "_data_drained"}, data_q.size(), 0);
        check({name, "_frame_cnt"}, frame_cnt, exp_frame_cnt);
        check({name, "_drops"}, n_drop, exp_drops);
        check({name, "_len_err"}, n_lenerr, exp_lenerr);
        check({name, "_len_err_nocheck"}, n_lenerr_nc, 0);
        check({name, "_data_pops"}, n_data_pops, exp_data_pops);
        check({name, "_illegal_pops"}, n_illegal, 0);
    endtask

    task automatic clear_model();
        ctrl_q.delete();
        data_q.delete();
        exp_q.delete();
        exp_frame_cnt = 0; exp_lenerr = 0; exp_drops = 0; exp_data_pops = 0;
        n_lenerr = 0; n_lenerr_nc = 0; n_drop = 0; n_data_pops = 0; n_ctrl_pops = 0;
        prev_stall = 1'b0;
        drive_fifo();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n;
        vectors = 0; miscompares = 0; cyc = 0; n_illegal = 0;
        ready_mode = 0; rand_env = 1'b0;
        ctrl_hold = 1'b0; data_hold = 1'b0;
        tready = 1'b1; enable = 1'b1;
        rst_n = 1'b0;
        clear_model();
        mark_reset();

        // Reset state
        #12;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_underrun", underrun_cnt, 0);
        check("rst_rden", {ctrl_rden, data_rden}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 64-byte frame, tready high: latency and back-to-back beats
        mark_reset();
        push_frame(64, 0, 1'b0, 8, 1'b0, 8'hFF);
        finish_scn("full64", 200);
        check("lat_first_data_pop", data_pop_cyc - ctrl_pop_cyc, 1);
        check("lat_first_tvalid", tvalid_cyc - ctrl_pop_cyc, 2);
        check("beats_contiguous", last_cyc - tvalid_cyc, 7);
        check("full64_underrun", underrun_cnt, 0);

        // 60-byte frame with tready toggling
        ready_mode = 1;
        push_frame(60, 0, 1'b0, 8, 1'b0, 8'h0F);
        finish_scn("toggle60", 200);

        // 63 bytes against length 64: bad-frame marking
        ready_mode = 0;
        push_frame(64, 0, 1'b0, 8, 1'b0, 8'h7F);
        finish_scn("short63", 200);

        // Dropped frame followed by a normal one
        push_frame(32, 0, 1'b1, 4, 1'b0, 8'hFF);
        push_frame(-1, 0, 1'b0, 3, 1'b0, 8'h03);
        finish_scn("drop", 200);

        // Three back-to-back frames under random ready
        ready_mode = 2;
        push_frame(-1, 0, 1'b0, 2, 1'b1, 8'h01);
        push_frame(-1, 0, 1'b0, 1, 1'b0, 8'hFF);
        push_frame(-1, 2, 1'b0, 5, 1'b1, 8'h3F);
        finish_scn("b2b", 300);

        // Deasserting enable mid-frame must not abort it
        ready_mode = 0;
        mark_reset();
        push_frame(-1, 0, 1'b0, 8, 1'b0, 8'hFF);
        n = 0;
        while (ctrl_pop_cyc < 0 && n < 20) begin step(); n++; end
        enable = 1'b0;
        finish_scn("en_off_midframe", 200);
        p0 = n_ctrl_pops;
        push_frame(-1, 0, 1'b0, 2, 1'b0, 8'hFF);
        for (int i = 0; i < 5; i++) step();
        check("en_off_no_pop", n_ctrl_pops - p0, 0);
        enable = 1'b1;
        finish_scn("en_on", 200);

        // Reset during beat 3 of 8
        mark_reset();
        push_frame(64, 0, 1'b0, 8, 1'b0, 8'hFF);
        push_frame(-1, 0, 1'b0, 1, 1'b0, 8'hFF);
        n = 0;
        while (tvalid_cyc < 0 && n < 20) begin step(); n++; end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", tvalid, 1'b0);
        check("mid_rst_tdata", tdata, 64'h0);
        check("mid_rst_side", {tkeep, tlast, tuser}, 10'h0);
        check("mid_rst_status", {busy, len_err, drop_pulse}, 3'b000);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_underrun", underrun_cnt, 0);
        check("mid_rst_rden", {ctrl_rden, data_rden}, 2'b00);
        repeat (2) @(posedge clk);
        clear_model();
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(-1, 0, 1'b0, 2, 1'b0, 8'hFF);
        for (int i = 0; i < 6; i++) step();
        check("post_rst_no_pop", n_ctrl_pops, 0);
        enable = 1'b1;
        finish_scn("post_rst", 200);

        // Data FIFO empty for five cycles inside a frame
        mark_reset();
        data_hold = 1'b1;
        push_frame(64, 0, 1'b0, 8, 1'b0, 8'hFF);
        n = 0;
        while (ctrl_pop_cyc < 0 && n < 20) begin step(); n++; end
        for (int i = 0; i < 5; i++) begin
            step();
            check("underrun_no_tvalid", tvalid, 1'b0);
        end
        data_hold = 1'b0;
        drive_fifo();
        finish_scn("underrun", 200);
        check("underrun_cnt", underrun_cnt, 5);

        // Randomized frames against the scoreboard
        ready_mode = 2;
        rand_env = 1'b1;
        for (int f = 0; f < 40; f++) begin
            push_frame(-1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) - 5 : 0,
                       ($urandom_range(0, 4) == 0), int'($urandom_range(1, 12)), 1'b1,
                       8'($urandom_range(1, 255)));
        end
        n = 0;
        while (n < 20000 && !(ctrl_q.size() == 0 && data_q.size() == 0 && exp_q.size() == 0 && !busy)) begin
            step();
            n++;
        end
        rand_env = 1'b0;
        data_hold = 1'b0;
        enable = 1'b1;
        drive_fifo();
        finish_scn("random", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ofm_tx_reader.md
OFM_TX_READER -- requirements
Module: ofm_tx_reader

Interface
REQ-001 Parameter C_LEN_CHECK, default 1, enables the byte-length check of REQ-016.
REQ-002 Parameter C_UNDERRUN_W, default 16, sets the width of underrun_cnt.
REQ-003 tx_clk  in  1  sole clock; one clock, all logic in tx_clk domain.
REQ-004 tx_resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 ctrl_fifo_rdata  in  64  FWFT ctrl word: [15:0] frame byte length, [16] drop flag, [63:17] reserved (ignored).
REQ-006 ctrl_fifo_empty  in  1  ctrl FIFO empty.
REQ-007 ctrl_fifo_rden  out  1  pop ctrl FIFO, one-cycle pulse.
REQ-008 data_fifo_rdata  in  73  FWFT data word: [63:0] data, [71:64] keep (bit n = byte n valid), [72] last.
REQ-009 data_fifo_empty  in  1  data FIFO empty.
REQ-010 data_fifo_rden  out  1  pop data FIFO.
REQ-011 tx_axis_tdata/tkeep/tlast/tuser  out  64/8/1/1  AXI-Stream beat to MAC; tuser=1 marks bad frame on last beat.
REQ-012 tx_axis_tvalid  out  1 / tx_axis_tready  in  1  AXI-Stream handshake.
REQ-013 enable  in  1 / busy  out  1 / len_err  out  1 (pulse) / drop_pulse  out  1 (pulse) / frame_cnt  out  32 / underrun_cnt  out  C_UNDERRUN_W.

Function
REQ-014 FSM states IDLE, SEND, DROP; IDLE -> (enable & !ctrl_fifo_empty) pulses ctrl_fifo_rden, latches len and drop flag, goes to DROP if drop=1 else SEND.
REQ-015 SEND: data_fifo_rden = !data_fifo_empty & (output register empty | tready); popped word loads the output register next edge; popping a word with last=1 returns to IDLE.
REQ-016 Byte counter (16-bit, cleared on ctrl pop) adds popcount(keep) per popped beat; on last beat, if C_LEN_CHECK and total != latched len, tuser=1 on that beat and len_err pulses one cycle.
REQ-017 DROP: data_fifo_rden = !data_fifo_empty; no tvalid; on popped last=1, drop_pulse one cycle, return to IDLE.
REQ-018 Output register is a one-entry stage: tvalid held with stable tdata/tkeep/tlast/tuser until tready; cleared on accept unless refilled same cycle (full throughput, one beat/cycle).
REQ-019 Latency: ctrl visible in IDLE -> ctrl pop cycle N, first data pop N+1, first tvalid N+2.
REQ-020 Next frame's ctrl pop allowed while the previous last beat waits in the output register; minimum one IDLE cycle between frames.
REQ-021 Underrun: in SEND with data_fifo_empty and output register empty, underrun_cnt increments per cycle, saturating at all-ones; tvalid stays 0 (no bubble fill).
REQ-022 frame_cnt increments (wraps) on accepted beat with tlast=1; dropped frames not counted.
REQ-023 enable=0 never aborts a frame in progress; only blocks the IDLE ctrl pop.
REQ-024 busy = (state != IDLE) | tvalid.
REQ-025 Never pop a FIFO when its empty=1; never pop ctrl outside IDLE.

Reset
REQ-026 tx_resetn low: state IDLE, all outputs 0, all counters 0, output register empty, immediately (asynchronous).
REQ-027 Reset mid-frame abandons the frame; FIFO contents untouched; exit from reset starts in IDLE.

Structure
REQ-028 Shared package ofm_pkg holds ctrl/data word field offsets, widths (64, 73, 8), and state encoding.
REQ-029 One sub-module ofm_axis_reg (one-entry output register with ready/valid) is natural; FSM and counters stay in the top.

Verification
REQ-030 Ctrl len=64, 8 full beats (keep=0xFF, last on 8th), tready=1 -> 8 consecutive tvalid beats, tlast on 8th, tuser=0, frame_cnt=1.
REQ-031 Ctrl len=60, beats 8x with last keep=0x0F, tready toggling 1/0 -> data stable while stalled, 8 beats delivered, tuser=0.
REQ-032 Ctrl len=64, 8 beats totalling 63 bytes -> tuser=1 on last beat, len_err single pulse; C_LEN_CHECK=0 -> tuser=0.
REQ-033 Ctrl drop=1, 4 beats -> no tvalid, 4 data pops, drop_pulse once, frame_cnt unchanged; following normal frame transmits.
REQ-034 Data FIFO empty 5 cycles mid-frame -> underrun_cnt=5, tvalid low those cycles, frame then completes.
REQ-035 tx_resetn low during beat 3 of 8 -> all outputs 0 same cycle; after release, IDLE, next ctrl pop only with enable=1.
